// File: rtl/controller_pkg.sv
// controller_pkg: shared types and constants for the game-pad poller.
//   - poll_state_e     : poll sequencer states
//   - BTN_*            : bit positions inside a button byte (A is the MSB,
//                        so it is the first bit shifted out of a pad)
//   - POLL_HALF_PERIODS: controller half-clock periods in one poll
//                        (2 for the latch pulse + 2 per button * 8)
//   - LAST_BIT         : index of the final button in a poll
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    DONE   = 3'd4
  } poll_state_e;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int POLL_HALF_PERIODS = 18;

  localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/controller_sync_m.sv
// controller_sync_m: STAGES-deep flip-flop synchroniser for one serial pad
// data line. Resets to 1, which on these active-low lines reads as
// "button released".
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d_i   in  raw pin level
//   q_o   out synchronised level (STAGES cycles later; STAGES=0 bypasses)
module controller_sync_m #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;

      // Shift chain: stage 0 captures the pin, last stage feeds the sampler.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/controller_poller.sv
// controller_poller: drives latch / shift clock to two serial game pads,
// samples both active-low data lines once per button and publishes
// active-high button bytes, updated atomically once per poll.
//   clk, rst_n          system clock, asynchronous active-low reset
//   poll_start          one-cycle poll request (ignored while busy)
//   data_1_B, data_2_B  serial pad data, active-low
//   latch               parallel-load strobe to both pads
//   ctrl_clk            registered shift clock level
//   ctrl_clk_en         one-cycle strobe on each ctrl_clk rising cycle
//   busy                poll in progress
//   done                one-cycle pulse when button bytes are updated
//   buttons_1/2         {a,b,select,start,up,down,left,right}, active-high
// All outputs are registered; their next values are decoded from the
// next-state signals so they line up exactly with the state they describe.
module controller_poller
  import controller_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll_start,
  input  logic       data_1_B,
  input  logic       data_2_B,
  output logic       latch,
  output logic       ctrl_clk,
  output logic       ctrl_clk_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  poll_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;   // second half of the latch pulse
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh1_q, sh1_d, sh2_q, sh2_d;
  logic [7:0]    btn1_q, btn1_d, btn2_q, btn2_d;
  logic          latch_q, latch_d, cclk_q, cclk_d, cen_q, cen_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          d1_sync_s, d2_sync_s, cnt_last_s;

  controller_sync_m #(.STAGES(SYNC_STAGES)) u_sync_1 (
    .clk(clk), .rst_n(rst_n), .d_i(data_1_B), .q_o(d1_sync_s)
  );

  controller_sync_m #(.STAGES(SYNC_STAGES)) u_sync_2 (
    .clk(clk), .rst_n(rst_n), .d_i(data_2_B), .q_o(d2_sync_s)
  );

  assign cnt_last_s = (cnt_q == CNT_LAST);

  // Next-state, counters, shift registers and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;

    case (state_q)
      IDLE: begin
        if (poll_start) begin
          state_d = LATCH;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          if (half_q) begin
            state_d = BIT_LO;
            half_d  = 1'b0;
            bit_d   = 3'd0;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_LO: begin
        if (cnt_last_s) begin
          // Data has been stable for at least one synchroniser delay here.
          cnt_d   = '0;
          sh1_d   = {sh1_q[6:0], ~d1_sync_s};
          sh2_d   = {sh2_q[6:0], ~d2_sync_s};
          state_d = BIT_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_HI: begin
        if (cnt_last_s) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = BIT_LO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    latch_d = (state_d == LATCH);
    cclk_d  = (state_d == BIT_HI) || ((state_d == LATCH) && half_d);
    // First cycle of every high phase: counter has just wrapped to zero.
    cen_d   = cclk_d && (cnt_d == '0);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    if (state_d == DONE) begin
      btn1_d = sh1_q;
      btn2_d = sh2_q;
    end else begin
      btn1_d = btn1_q;
      btn2_d = btn2_q;
    end
  end

  // State, counters, shift registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= 3'd0;
      sh1_q   <= 8'h00;
      sh2_q   <= 8'h00;
      btn1_q  <= 8'h00;
      btn2_q  <= 8'h00;
      latch_q <= 1'b0;
      cclk_q  <= 1'b0;
      cen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      btn1_q  <= btn1_d;
      btn2_q  <= btn2_d;
      latch_q <= latch_d;
      cclk_q  <= cclk_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign latch       = latch_q;
  assign ctrl_clk    = cclk_q;
  assign ctrl_clk_en = cen_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign buttons_1   = btn1_q;
  assign buttons_2   = btn2_q;

endmodule

// File: tb/tb_controller_poller.sv
module tb_controller_poller;
  import controller_pkg::*;

  localparam int H        = 4;
  localparam int DONE_CYC = POLL_HALF_PERIODS * H + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_start = 1'b0;
  logic       data_1_B, data_2_B;
  logic       latch, ctrl_clk, ctrl_clk_en, busy, done;
  logic [7:0] buttons_1, buttons_2;

  int checks = 0;
  int errors = 0;

  // Controller models: pressed buttons (active-high) and two pad styles.
  logic [7:0] press1 = 8'h00, press2 = 8'h00;
  logic       use_async = 1'b0;
  logic [7:0] sr1_s = 8'h00, sr2_s = 8'h00, sr1_a = 8'h00, sr2_a = 8'h00;
  logic [7:0] last1 = 8'h00, last2 = 8'h00;

  always #5 clk = ~clk;

  controller_poller #(.CLK_DIV(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .poll_start(poll_start),
    .data_1_B(data_1_B), .data_2_B(data_2_B),
    .latch(latch), .ctrl_clk(ctrl_clk), .ctrl_clk_en(ctrl_clk_en),
    .busy(busy), .done(done), .buttons_1(buttons_1), .buttons_2(buttons_2)
  );

  // Synchronous-latch pad: runs on clk, acts only on ctrl_clk_en.
  always @(posedge clk) begin
    if (ctrl_clk_en) begin
      if (latch) begin
        sr1_s <= press1;
        sr2_s <= press2;
      end else begin
        sr1_s <= {sr1_s[6:0], 1'b0};
        sr2_s <= {sr2_s[6:0], 1'b0};
      end
    end
  end

  // Classic pad: acts on the rising edge of the shift clock pin.
  always @(posedge ctrl_clk) begin
    if (latch) begin
      sr1_a <= press1;
      sr2_a <= press2;
    end else begin
      sr1_a <= {sr1_a[6:0], 1'b0};
      sr2_a <= {sr2_a[6:0], 1'b0};
    end
  end

  assign data_1_B = use_async ? ~sr1_a[7] : ~sr1_s[7];
  assign data_2_B = use_async ? ~sr2_a[7] : ~sr2_s[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // One full poll: timing, strobe counts, hold behaviour and result bytes.
  task automatic run_poll(input logic [7:0] p1, input logic [7:0] p2, input logic async,
                          input logic [7:0] e1, input logic [7:0] e2,
                          input int ign_a, input int ign_b,
                          input int chg_at, input logic [7:0] chg_p1, input string name);
    int done_cyc = -1;
    int done_cnt = 0, busy_err = 0, hold_err = 0;
    int latch_cnt = 0, en_cnt = 0, clk_hi = 0, en_err = 0;
    logic [7:0] got1 = 8'h00, got2 = 8'h00;
    press1 = p1;
    press2 = p2;
    use_async = async;
    @(posedge clk); #1;
    poll_start = 1'b1;
    for (int k = 1; k <= DONE_CYC + 2; k++) begin
      @(posedge clk); #1;
      poll_start = (k == ign_a) || (k == ign_b);
      if (k == chg_at) press1 = chg_p1;
      if (latch) latch_cnt++;
      if (ctrl_clk) clk_hi++;
      if (ctrl_clk_en) en_cnt++;
      if (ctrl_clk_en && !ctrl_clk) en_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
        got1 = buttons_1;
        got2 = buttons_2;
      end
      if (busy !== (k <= DONE_CYC)) busy_err++;
      if (k < DONE_CYC && (buttons_1 !== last1 || buttons_2 !== last2)) hold_err++;
    end
    poll_start = 1'b0;
    check({name, "_done_cycle"}, done_cyc, DONE_CYC);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_busy_window"}, busy_err, 0);
    check({name, "_hold_old"}, hold_err, 0);
    check({name, "_latch_cycles"}, latch_cnt, 2 * H);
    check({name, "_clk_high_cycles"}, clk_hi, 9 * H);
    check({name, "_clk_en_pulses"}, en_cnt + 100 * en_err, 9);
    check({name, "_buttons_1"}, {24'h0, got1}, {24'h0, e1});
    check({name, "_buttons_2"}, {24'h0, got2}, {24'h0, e2});
    check({name, "_buttons_after"}, {16'h0, buttons_1, buttons_2}, {16'h0, e1, e2});
    last1 = e1;
    last2 = e2;
  endtask

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic       async;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int idle_err;
    logic [7:0] r1, r2;
    logic       ra;

    // A+right on pad 1, start on pad 2, both pad styles, plus edge patterns.
    tbl[0] = '{8'h81, 8'h10, 1'b0, 8'h81, 8'h10};
    tbl[1] = '{8'h81, 8'h10, 1'b1, 8'h81, 8'h10};
    tbl[2] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00};
    tbl[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF};
    tbl[4] = '{8'h55, 8'hAA, 1'b0, 8'h55, 8'hAA};

    // Reset and idle behaviour.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {latch, ctrl_clk, ctrl_clk_en, busy, done, buttons_1, buttons_2}, 32'h0);
    rst_n = 1'b1;
    idle_err = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if ({latch, ctrl_clk, ctrl_clk_en, busy, done, buttons_1, buttons_2} !== 21'h0) idle_err++;
    end
    check("idle_quiet", idle_err, 0);

    for (int i = 0; i < 5; i++) begin
      run_poll(tbl[i].p1, tbl[i].p2, tbl[i].async, tbl[i].e1, tbl[i].e2,
               -1, -1, -1, 8'h00, $sformatf("vec%0d", i));
    end

    // Requests during a poll and during DONE are dropped.
    run_poll(8'h42, 8'h24, 1'b0, 8'h42, 8'h24, 10, DONE_CYC, -1, 8'h00, "ignore_start");

    // Pad state changes after the latch pulse: the latched value wins.
    run_poll(8'h81, 8'h10, 1'b0, 8'h81, 8'h10, -1, -1, 2 * H + 3, 8'h3C, "midchg_sync");
    run_poll(8'hC3, 8'h01, 1'b1, 8'hC3, 8'h01, -1, -1, 2 * H + 3, 8'h18, "midchg_async");

    // Random pad patterns and pad styles.
    for (int r = 0; r < 6; r++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      run_poll(r1, r2, ra, r1, r2, -1, -1, -1, 8'h00, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a poll.
    press1 = 8'h99;
    press2 = 8'h66;
    @(posedge clk); #1;
    poll_start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      poll_start = 1'b0;
    end
    check("midpoll_busy_before_reset", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midpoll_reset_outputs", {latch, ctrl_clk, ctrl_clk_en, busy, done, buttons_1, buttons_2}, 32'h0);
    last1 = 8'h00;
    last2 = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_poll(8'h81, 8'h10, 1'b0, 8'h81, 8'h10, -1, -1, -1, 8'h00, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_poller.md
# controller_poller

Sequences two serial game-pad shift registers (8 buttons each, active-low serial data) by generating the latch and shift-clock waveforms, sampling both data lines, and presenting debounced-per-frame, active-high button bytes to the CPU-side register file. One poll is started per request (normally once per vsync). It sits between the controller port pins (or the controller simulation model) and the memory-mapped controller registers.

## Interface
Parameters:
- CLK_DIV, 4: system cycles per half-period of the controller clock (H); legal range SYNC_STAGES+1 ≤ CLK_DIV ≤ 255
- SYNC_STAGES, 2: flip-flop synchroniser depth on each data input; 0 = bypass

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- poll_start  in  1  one-cycle request to begin a poll; accepted only when busy=0
- data_1_B  in  1  serial data from controller 1, active-low
- data_2_B  in  1  serial data from controller 2, active-low
- latch  out  1  parallel-load strobe to both controllers
- ctrl_clk  out  1  shift clock to both controllers (registered level)
- ctrl_clk_en  out  1  one-cycle strobe coincident with every ctrl_clk rising cycle (drives controllers' clock-enable when they run on clk)
- busy  out  1  poll in progress
- done  out  1  one-cycle pulse: new button bytes valid
- buttons_1  out  8  controller 1 state, active-high, {a,b,select,start,up,down,left,right}
- buttons_2  out  8  controller 2 state, same order

## Operation
- States: IDLE, LATCH, BIT_LO, BIT_HI, DONE.
- IDLE: all strobes low; poll_start → LATCH, half-counter and bit index cleared.
- LATCH: 2H cycles, latch=1; ctrl_clk=0 first H cycles, =1 last H cycles; ctrl_clk_en pulses on first high cycle (loads synchronous-latch controllers). → BIT_LO, bit index 0.
- BIT_LO: H cycles, latch=0, ctrl_clk=0; on last cycle sample synchronised data: shreg_n <= {shreg_n[6:0], ~data_n}. → BIT_HI.
- BIT_HI: H cycles, ctrl_clk=1, ctrl_clk_en on first cycle (controllers shift). After bit 7 → DONE, else bit index+1 → BIT_LO.
- DONE: 1 cycle; done=1; buttons_1/2 <= shift registers atomically; → IDLE.
- Eight samples, eight shift pulses per poll; first sample is A (MSB).
- Bit index 3 bits; half-counter width $clog2(CLK_DIV).

## Timing
- poll_start accepted at cycle 0 → latch high cycles 1..2H; ctrl_clk_en at H+1.
- Bit i sample at cycle 2H(i+1)+H; shift strobe at 2H(i+1)+H+1.
- done and buttons update at cycle 18H+1; busy high cycles 1..18H+1 inclusive.
- poll_start while busy (including the DONE cycle): ignored, not queued.
- buttons_n hold previous values throughout a poll; change only in DONE.
- Reset (any time, including mid-poll): state IDLE, latch=0, ctrl_clk=0, ctrl_clk_en=0, busy=0, done=0, buttons_1=buttons_2=8'h00, shift registers 0, synchronisers preset to 1 (released).
- Data path latency from pin to sample: SYNC_STAGES cycles; CLK_DIV ≥ SYNC_STAGES+1 guarantees settled data at sample point.

## Structure
- controller_pkg: state enum typedef; button bit index constants (BTN_A=7 … BTN_RIGHT=0); POLL_HALF_PERIODS=18.
- Sub-module controller_sync_m: SYNC_STAGES-deep synchroniser with reset-to-1, instantiated once per data line.
- Top: FSM, half-period counter, bit index, two shift registers, output registers.

## Test plan
- Reset then idle, CLK_DIV=4: all outputs 0, buttons 8'h00, latch/ctrl_clk never toggle.
- Model controllers (SYNC_LATCH=1, clocked by clk with ctrl_clk_en) pressing A+right / start: poll_start at 0 → done at cycle 73, buttons_1=8'h81, buttons_2=8'h10.
- Same with SYNC_LATCH=0 models driven by ctrl_clk: identical buttons and done timing.
- poll_start pulsed at cycles 10 and 73 of a poll: both ignored, single done, busy low at 74.
- Buttons change mid-poll: buttons_1 stays at old value until done, then shows latched value from LATCH phase.
- rst_n asserted at cycle 30 mid-poll: outputs immediately reset values; new poll after release completes in 18H+1 cycles with correct bytes.
